// File: rtl/dense_cmd_encoder.sv
// dense_cmd_encoder: captures one dense-layer command and serialises it into a 32-bit word stream.
// Define DENSE_ENC_CHECKSUM_EN to append an XOR trailer word and set header bit 22.
module dense_cmd_encoder #(
    parameter int unsigned size            = 3,
    parameter int unsigned data_size       = 16,
    parameter int unsigned cost_type_size  = 8,
    parameter int unsigned dense_type_size = 4,
    parameter int unsigned act_type_size   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [act_type_size-1:0]    act_type,
    input  logic [dense_type_size-1:0]  dense_type,
    input  logic [cost_type_size-1:0]   cost_type,
    input  logic                        is_update,
    input  logic                        load_w,
    input  logic                        backprop_cost,
    input  logic [31:0]                 w_layer_index,
    input  logic [31:0]                 w_row_index,
    input  logic [data_size*size-1:0]   w,
    input  logic [data_size*size-1:0]   x,
    input  logic [data_size*size-1:0]   label,
    output logic [31:0]                 out_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);

    localparam int unsigned cw = (size > 1) ? $clog2(size) : 1;
    localparam int unsigned vw = data_size * size;
`ifdef DENSE_ENC_CHECKSUM_EN
    localparam bit csum_en = 1'b1;
`else
    localparam bit csum_en = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StHdr, StLidx, StRidx, StW, StX, StLbl, StCrc} state_e;

    state_e          state_q, nxt_state;
    logic [cw-1:0]   cnt_q, nxt_cnt, cnt_inc;
    logic [31:0]     csum_q, nxt_word, hdr;
    logic            nxt_valid, nxt_last, last_elem, go_x, go_lbl, go_end;
    logic            loadw_q, bpc_q;
    logic [31:0]     lidx_q, ridx_q;
    logic [vw-1:0]   w_q, x_q, lbl_q;

    function automatic logic [31:0] elem(input logic [vw-1:0] v, input logic [cw-1:0] i);
        return 32'(v[int'(i)*data_size +: data_size]);
    endfunction

    assign hdr = {8'hA5, 1'b0, csum_en, 3'b000, backprop_cost, load_w, is_update,
                  8'(cost_type), 4'(dense_type), 4'(act_type)};

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    // Next word/state to present once the current word is handshaken.
    always_comb begin
        last_elem = (cnt_q == cw'(size - 1));
        cnt_inc   = cnt_q + 1'b1;
        go_x      = 1'b0;
        go_lbl    = 1'b0;
        go_end    = 1'b0;
        nxt_state = state_q;
        nxt_cnt   = cnt_inc;
        nxt_word  = 32'd0;
        nxt_valid = 1'b1;
        nxt_last  = 1'b0;
        case (state_q)
            StHdr: begin
                if (loadw_q) begin
                    nxt_state = StLidx;
                    nxt_word  = lidx_q;
                end else begin
                    go_x = 1'b1;
                end
            end
            StLidx: begin
                nxt_state = StRidx;
                nxt_word  = ridx_q;
            end
            StRidx: begin
                nxt_state = StW;
                nxt_cnt   = '0;
                nxt_word  = elem(w_q, '0);
            end
            StW: begin
                if (!last_elem) nxt_word = elem(w_q, cnt_inc);
                else            go_x = 1'b1;
            end
            StX: begin
                if (!last_elem) begin
                    nxt_word = elem(x_q, cnt_inc);
                    nxt_last = !csum_en && !bpc_q && (cnt_inc == cw'(size - 1));
                end else if (bpc_q) begin
                    go_lbl = 1'b1;
                end else begin
                    go_end = 1'b1;
                end
            end
            StLbl: begin
                if (!last_elem) begin
                    nxt_word = elem(lbl_q, cnt_inc);
                    nxt_last = !csum_en && (cnt_inc == cw'(size - 1));
                end else begin
                    go_end = 1'b1;
                end
            end
            default: go_end = 1'b1;
        endcase
        if (go_x) begin
            nxt_state = StX;
            nxt_cnt   = '0;
            nxt_word  = elem(x_q, '0);
            nxt_last  = !csum_en && !bpc_q && (size == 1);
        end
        if (go_lbl) begin
            nxt_state = StLbl;
            nxt_cnt   = '0;
            nxt_word  = elem(lbl_q, '0);
            nxt_last  = !csum_en && (size == 1);
        end
        if (go_end) begin
            nxt_cnt = '0;
            if (csum_en && state_q != StCrc) begin
                nxt_state = StCrc;
                nxt_word  = csum_q;
                nxt_last  = 1'b1;
            end else begin
                nxt_state = StIdle;
                nxt_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            csum_q    <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            loadw_q   <= 1'b0;
            bpc_q     <= 1'b0;
            lidx_q    <= '0;
            ridx_q    <= '0;
            w_q       <= '0;
            x_q       <= '0;
            lbl_q     <= '0;
        end else if (state_q == StIdle) begin
            if (cmd_valid) begin
                state_q   <= StHdr;
                cnt_q     <= '0;
                csum_q    <= hdr;
                out_word  <= hdr;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                loadw_q   <= load_w;
                bpc_q     <= backprop_cost;
                lidx_q    <= w_layer_index;
                ridx_q    <= w_row_index;
                w_q       <= w;
                x_q       <= x;
                lbl_q     <= label;
            end
        end else if (out_valid && out_ready) begin
            state_q   <= nxt_state;
            cnt_q     <= nxt_cnt;
            csum_q    <= csum_q ^ nxt_word;
            out_word  <= nxt_word;
            out_valid <= nxt_valid;
            out_last  <= nxt_last;
        end
    end

endmodule
